// File: rtl/sfu_result_sink.sv
// sfu_result_sink: buffers SFU results in a small show-ahead FIFO.
// Each entry is {selop, res_data}. The head entry is presented
// downstream with a valid/ready handshake. Producer backpressure
// (stall) is derived from the registered occupancy only. A write
// into a full FIFO that is not relieved by a same-cycle pop is
// dropped, and the drop is remembered in the sticky overflow flag.

module sfu_result_sink #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AFULL = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [DW-1:0]            res_data,
  input  logic [2:0]               selop,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DW-1:0]            out_data,
  output logic [2:0]               out_tag,
  output logic                     stall,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = DW + 3;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL);

  // Entry storage; intentionally has no reset.
  logic [EW-1:0] mem [DEPTH];

  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count_q;
  logic          overflow_q;

  // Last popped entry, shown while the FIFO is empty so the outputs
  // do not wander through stale memory.
  logic [EW-1:0] last_entry;

  logic [EW-1:0] head;
  logic          is_empty;
  logic          is_full;
  logic          pop;
  logic          push;
  logic          drop;

  // Handshake decode: a pop frees a slot, so a full FIFO can still
  // accept a write in the same cycle. Flush overrides everything.
  always_comb begin
    is_empty = (count_q == '0);
    is_full  = (count_q == DEPTH_C);
    pop      = !flush && !is_empty && out_ready;
    push     = !flush && we && (!is_full || pop);
    drop     = !flush && we && is_full && !pop;
    head     = mem[rd_ptr];
  end

  // Write port: store the tagged result at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {selop, res_data};
    end
  end

  // Pointer, occupancy and sticky overflow state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else if (flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + CW'(1);
      end else if (pop && !push) begin
        count_q <= count_q - CW'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Capture the entry leaving the head so it can be held while empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_entry <= '0;
    end else if (pop) begin
      last_entry <= head;
    end
  end

  // Registered-state outputs; none depend combinationally on we or out_ready.
  always_comb begin
    out_valid = !is_empty;
    stall     = (count_q >= AFULL_C);
    overflow  = overflow_q;
    count     = count_q;
    if (is_empty) begin
      out_data = last_entry[DW-1:0];
      out_tag  = last_entry[EW-1:DW];
    end else begin
      out_data = head[DW-1:0];
      out_tag  = head[EW-1:DW];
    end
  end

endmodule

// File: tb/tb_sfu_result_sink.sv
// Testbench for sfu_result_sink: directed scenarios followed by random
// traffic, all checked against a queue-based reference model.

module tb_sfu_result_sink;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int AFULL = 6;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          we = 1'b0;
  logic [DW-1:0] res_data = '0;
  logic [2:0]    selop = '0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic [2:0]    out_tag;
  logic          stall;
  logic          overflow;
  logic [CW-1:0] count;

  logic [DW+2:0] model_q[$];
  bit            model_ovf;

  int check_count = 0;
  int error_count = 0;

  sfu_result_sink #(.DW(DW), .DEPTH(DEPTH), .AFULL(AFULL)) dut (
    .clk(clk), .rst(rst), .we(we), .res_data(res_data), .selop(selop),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .stall(stall),
    .overflow(overflow), .count(count)
  );

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Compare every visible output against the model's current contents.
  task automatic check_state(input string where);
    int sz;
    logic [DW+2:0] hd;
    sz = model_q.size();
    check_output({where, ".valid"},    64'(out_valid), 64'(sz != 0));
    check_output({where, ".count"},    64'(count),     64'(sz));
    check_output({where, ".stall"},    64'(stall),     64'(sz >= AFULL));
    check_output({where, ".overflow"}, 64'(overflow),  64'(model_ovf));
    if (sz != 0) begin
      hd = model_q[0];
      check_output({where, ".data"}, 64'(out_data), 64'(hd[DW-1:0]));
      check_output({where, ".tag"},  64'(out_tag),  64'(hd[DW+2:DW]));
    end
  endtask

  // One clock cycle: check, drive inputs, advance model, wait past the edge.
  task automatic apply_stimulus(input logic w, input logic [DW-1:0] d,
                                input logic [2:0] t, input logic f, input logic r,
                                input string where);
    bit do_pop;
    bit was_full;
    check_state(where);
    we        = w;
    res_data  = w ? d : 'x;
    selop     = w ? t : 'x;
    flush     = f;
    out_ready = r;
    if (f) begin
      model_q.delete();
      model_ovf = 0;
    end else begin
      was_full = (model_q.size() == DEPTH);
      do_pop   = (model_q.size() != 0) && r;
      if (do_pop) void'(model_q.pop_front());
      if (w) begin
        if (!was_full || do_pop) model_q.push_back({t, d});
        else model_ovf = 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 1'b0; flush = 1'b0; out_ready = 1'b0;
    res_data = '0; selop = '0;
  endtask

  initial begin
    model_ovf = 0;
    // Power-on reset held across a few edges.
    repeat (3) @(posedge clk);
    #1;
    check_state("reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Single push, hold with out_ready low, then accept.
    apply_stimulus(1'b1, 32'h0000_00A5, 3'b001, 1'b0, 1'b0, "s1_push");
    check_output("s1_data_next", 64'(out_data), 64'h0000_00A5);
    check_output("s1_tag_next",  64'(out_tag),  64'h1);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b0, "s1_hold");
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, "s1_pop");
    check_output("s1_valid_after_pop", 64'(out_valid), 64'h0);

    // Almost-full threshold.
    for (int i = 0; i < 6; i++)
      apply_stimulus(1'b1, DW'(i + 16), 3'(i), 1'b0, 1'b0, "s2_fill");
    check_output("s2_stall_at6", 64'(stall), 64'h1);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, "s2_pop");
    check_output("s2_stall_at5", 64'(stall), 64'h0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "s2_flush");

    // Overflow and in-order drain.
    for (int i = 1; i <= 9; i++)
      apply_stimulus(1'b1, DW'(i), 3'(i), 1'b0, 1'b0, "s3_fill");
    check_output("s3_count_full", 64'(count), 64'(DEPTH));
    check_output("s3_overflow", 64'(overflow), 64'h1);
    for (int i = 1; i <= 8; i++) begin
      check_output("s3_drain_order", 64'(out_data), 64'(i));
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, "s3_drain");
    end
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "s3_flush");

    // Full with simultaneous push and pop, pointers wrapping.
    for (int i = 0; i < 8; i++)
      apply_stimulus(1'b1, DW'(100 + i), 3'(i), 1'b0, 1'b0, "s4_fill");
    for (int i = 0; i < 16; i++) begin
      check_output("s4_stream_order", 64'(out_data), 64'(100 + i));
      apply_stimulus(1'b1, DW'(108 + i), 3'(i), 1'b0, 1'b1, "s4_stream");
    end
    check_output("s4_count", 64'(count), 64'(DEPTH));
    check_output("s4_no_overflow", 64'(overflow), 64'h0);
    apply_stimulus(1'b0, '0, '0, 1'b1, 1'b0, "s4_flush");

    // Flush beats concurrent push/pop and clears overflow.
    for (int i = 0; i < 9; i++)
      apply_stimulus(1'b1, DW'(200 + i), 3'(i), 1'b0, 1'b0, "s5_fill");
    for (int i = 0; i < 3; i++)
      apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, "s5_pop");
    apply_stimulus(1'b1, 32'hDEAD_BEEF, 3'b111, 1'b1, 1'b1, "s5_flush");
    check_output("s5_count", 64'(count), 64'h0);
    check_output("s5_valid", 64'(out_valid), 64'h0);
    check_output("s5_overflow", 64'(overflow), 64'h0);
    check_output("s5_stall", 64'(stall), 64'h0);
    apply_stimulus(1'b0, '0, '0, 1'b0, 1'b1, "s5_after");

    // Asynchronous reset between edges with four entries buffered.
    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b1, DW'(300 + i), 3'(i), 1'b0, 1'b0, "s6_fill");
    check_output("s6_count_pre", 64'(count), 64'h4);
    idle_inputs();
    #3;
    rst = 1'b0;
    #1;
    check_output("s6_valid_async", 64'(out_valid), 64'h0);
    check_output("s6_count_async", 64'(count), 64'h0);
    check_output("s6_stall_async", 64'(stall), 64'h0);
    check_output("s6_ovf_async", 64'(overflow), 64'h0);
    model_q.delete();
    model_ovf = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    apply_stimulus(1'b1, 32'h1234_5678, 3'b010, 1'b0, 1'b0, "s6_repush");
    check_output("s6_repush_data", 64'(out_data), 64'h1234_5678);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      apply_stimulus(($urandom_range(0, 9) < 6), $urandom(), 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 59) == 0), ($urandom_range(0, 1) == 1), "rand");
    end
    check_state("final");

    $display("Result: errors=%0d of %0d checks", error_count, check_count);
    $finish;
  end

endmodule
